// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, segment constants and sizing helpers for the display controller
package cpu_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  typedef enum logic {IDLE, CONVERT} state_t;

  // Decimal digits of 2**w-1, i.e. ceil(w*log10(2)), never fewer than n.
  function automatic int bcd_digits(input int w, input int n);
    int d;
    d = (w * 30103 + 99999) / 100000;
    if (d < 1) d = 1;
    return (d > n) ? d : n;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - value/load request and display result bundle for seg_display_ctrl
interface seg_display_ctrl_if
  import cpu_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int N_DIGITS = 4
) ();

  logic [WORD_W-1:0]    value;
  logic                 load;
  logic                 mode;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  seg7_t [N_DIGITS-1:0] disp;

  modport master (output value, load, mode, input busy, done, overflow, disp);
  modport slave  (input value, load, mode, output busy, done, overflow, disp);

endinterface

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - nibble to active-low gfedcba segment decoder
module seven_seg
  import cpu_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - converts a captured word to hex or decimal seven-segment digits
// Decimal uses one double-dabble step per cycle; hex finishes one cycle after load.
module seg_display_ctrl
  import cpu_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int N_DIGITS = 4,
  parameter int BLANK_LZ = 1
) (
  input logic               clock,
  input logic               n_reset,
  seg_display_ctrl_if.slave bus
);

  localparam int BCD_D = bcd_digits(WORD_W, N_DIGITS);
  localparam int BCD_W = 4 * BCD_D;
  localparam int HEX_W = 4 * imax((WORD_W + 3) / 4, N_DIGITS);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  state_t               state;
  logic [WORD_W-1:0]    shreg;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 cur_mode;
  logic                 done_q;
  logic                 ovf_q;
  logic                 ovf_nxt;
  logic                 lead;
  seg7_t [N_DIGITS-1:0] disp_q;
  seg7_t [N_DIGITS-1:0] disp_nxt;
  logic [HEX_W-1:0]     hex_pad;
  logic [3:0]           dig [N_DIGITS];
  seg7_t                raw [N_DIGITS];

  // Zero-extend so nibbles past WORD_W read as zero.
  assign hex_pad = HEX_W'(shreg);

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < BCD_D; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    bcd_nxt = BCD_W'({bcd_adj, shreg[WORD_W-1]});
  end

  always_comb begin
    ovf_nxt = cur_mode ? ((bcd_nxt >> (4 * N_DIGITS)) != '0)
                       : ((hex_pad >> (4 * N_DIGITS)) != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      dig[i] = cur_mode ? bcd_nxt[4*i +: 4] : hex_pad[4*i +: 4];
    end
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dec
    seven_seg u_seg (
      .nibble (dig[i]),
      .seg    (raw[i])
    );
  end

  // Walk down from the top digit; blanking stops at the first nonzero digit and never reaches digit 0.
  always_comb begin
    lead     = (BLANK_LZ != 0);
    disp_nxt = '1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lead        = (i != 0) && lead && (dig[i] == 4'd0);
      disp_nxt[i] = ovf_nxt ? SEG_DASH : (lead ? SEG_BLANK : raw[i]);
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      cur_mode <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      disp_q   <= {N_DIGITS{SEG_BLANK}};
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            shreg    <= bus.value;
            cur_mode <= bus.mode;
            bcd      <= '0;
            cnt      <= '0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (cur_mode) begin
            bcd   <= bcd_nxt;
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
          end
          if (!cur_mode || cnt == LAST) begin
            disp_q <= disp_nxt;
            ovf_q  <= ovf_nxt;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == CONVERT);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.disp     = disp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - scoreboard bench driving five configurations of seg_display_ctrl in parallel
module tb_seg_display_ctrl;
  import cpu_pkg::*;

  localparam int NCFG = 5;

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 16;
      3: return 20;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_n(input int i);
    return (i == 4) ? 2 : 4;
  endfunction

  function automatic int cfg_blz(input int i);
    return (i == 0 || i == 3) ? 0 : 1;
  endfunction

  typedef struct {
    logic [27:0] disp;
    logic        ovf;
    int          due;
    int          lat;
  } exp_t;

  logic        clock   = 1'b0;
  logic        n_reset = 1'b0;
  logic        load    = 1'b0;
  logic        mode    = 1'b0;
  logic [31:0] stim    = '0;
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  logic        busy_v [NCFG];
  exp_t        q [NCFG][$];

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // Reference: digits by plain division, overflow by magnitude comparison.
  function automatic exp_t model(input int w, input int n, input int blz, input logic [31:0] v, input logic m);
    exp_t            r;
    longint unsigned val;
    longint unsigned p;
    int              d [4];
    int              msd;
    val   = longint'(v) & ((64'd1 << w) - 1);
    r.ovf = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 0;
    if (!m) begin
      for (int i = 0; i < n; i++) d[i] = int'((val >> (4 * i)) & 15);
      r.ovf = (val >> (4 * n)) != 0;
    end else begin
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      r.ovf = (val >= p);
      p = 1;
      for (int i = 0; i < n; i++) begin
        d[i] = int'((val / p) % 10);
        p = p * 10;
      end
    end
    msd = 0;
    for (int i = 0; i < n; i++) if (d[i] != 0) msd = i;
    r.disp = '1;
    for (int i = 0; i < n; i++) begin
      if (r.ovf)                      r.disp[7*i +: 7] = 7'b0111111;
      else if (blz != 0 && i > msd)   r.disp[7*i +: 7] = 7'b1111111;
      else                            r.disp[7*i +: 7] = seg_ref(d[i]);
    end
    r.lat = 0;
    r.due = 0;
    return r;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = cfg_w(g);
    localparam int N  = cfg_n(g);
    localparam int DB = 7 * N;

    seg_display_ctrl_if #(.WORD_W(W), .N_DIGITS(N)) bus ();

    assign bus.value = stim[W-1:0];
    assign bus.load  = load;
    assign bus.mode  = mode;
    assign busy_v[g] = bus.busy;

    seg_display_ctrl #(.WORD_W(W), .N_DIGITS(N), .BLANK_LZ(cfg_blz(g))) dut (
      .clock   (clock),
      .n_reset (n_reset),
      .bus     (bus)
    );

    int          busy_run;
    logic [DB-1:0] last_disp;
    logic        last_ovf;

    initial begin
      exp_t e;
      busy_run  = 0;
      last_disp = '1;
      last_ovf  = 1'b0;
      forever begin
        @(negedge clock);
        if (!n_reset) begin
          checks++;
          if (bus.disp !== {DB{1'b1}} || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL cfg%0d reset_state disp=%h busy=%b done=%b ovf=%b required disp=all-ones busy=0 done=0 ovf=0",
                     g, bus.disp, bus.busy, bus.done, bus.overflow);
          end
          busy_run  = 0;
          last_disp = '1;
          last_ovf  = 1'b0;
        end else begin
          if (bus.busy === 1'b1) busy_run++;
          checks++;
          if (bus.done === 1'b1) begin
            if (q[g].size() == 0) begin
              errors++;
              $display("FAIL cfg%0d spurious_done at cycle %0d disp=%h required no done", g, cyc, bus.disp);
            end else begin
              e = q[g].pop_front();
              if (bus.disp !== e.disp[DB-1:0] || bus.overflow !== e.ovf || cyc != e.due ||
                  busy_run != e.lat || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg%0d result disp=%h ovf=%b cycle=%0d busy_cycles=%0d busy=%b required disp=%h ovf=%b cycle=%0d busy_cycles=%0d busy=0",
                         g, bus.disp, bus.overflow, cyc, busy_run, bus.busy, e.disp[DB-1:0], e.ovf, e.due, e.lat);
              end
              last_disp = e.disp[DB-1:0];
              last_ovf  = e.ovf;
            end
            busy_run = 0;
          end else if (bus.disp !== last_disp || bus.overflow !== last_ovf) begin
            errors++;
            $display("FAIL cfg%0d hold disp=%h ovf=%b required disp=%h ovf=%b", g, bus.disp, bus.overflow, last_disp, last_ovf);
          end
        end
      end
    end
  end

  function automatic logic any_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NCFG; i++) b = b | (busy_v[i] === 1'b1);
    return b;
  endfunction

  // Called at a negedge: raises load for one cycle and records what each configuration should show.
  task automatic start(input logic [31:0] v, input logic m);
    exp_t e;
    stim = v;
    mode = m;
    load = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      e     = model(cfg_w(i), cfg_n(i), cfg_blz(i), v, m);
      e.lat = m ? cfg_w(i) : 1;
      e.due = cyc + 1 + e.lat;
      q[i].push_back(e);
    end
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_busy() && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy still high after %0d cycles, required idle", n);
    end
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    start(32'hA5, 1'b0);          // accepted on the first edge after release
    wait_idle();
    start(32'd255, 1'b1);    wait_idle();
    start(32'd12345, 1'b1);  wait_idle();
    start(32'd9999, 1'b1);   wait_idle();
    start(32'd0, 1'b0);      wait_idle();
    start(32'd0, 1'b1);      wait_idle();
    start(32'hFFFFFFFF, 1'b0); wait_idle();
    start(32'hFFFFFFFF, 1'b1); wait_idle();
    start(32'h10000, 1'b0);  wait_idle();

    // A second load mid-conversion must be ignored.
    start(32'd255, 1'b1);
    @(negedge clock);
    stim = 32'd0;
    mode = 1'b0;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    wait_idle();

    // Reset three cycles into a decimal conversion aborts it.
    start(32'd255, 1'b1);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2;
    n_reset = 1'b0;
    for (int i = 0; i < NCFG; i++) q[i].delete();
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    repeat (2) @(negedge clock);
    start(32'd7, 1'b1);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      v = (it % 2 == 1) ? ($urandom & 32'hFFFFF) : 32'($urandom_range(0, 40));
      start(v, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    for (int i = 0; i < NCFG; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL cfg%0d pending_results outstanding=%0d required 0", i, q[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
